// File: rtl/pix_stream_pkg.sv
// Shared types and constants for the pixel stream packer.
// Holds the FSM state enum, the frame sync bytes and the mode-byte layout.
package pix_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_WAIT_SOF,
        ST_CAPTURE,
        ST_DRAIN
    } state_e;

    localparam logic [7:0] SYNC0 = 8'hA5;
    localparam logic [7:0] SYNC1 = 8'h5A;

    typedef struct packed {
        logic [4:0] rsvd;
        logic       gray;
        logic [1:0] decim;
    } mode_byte_t;

    function automatic logic [7:0] mode_byte(
        input logic       gray,
        input logic [1:0] decim
    );
        mode_byte_t m;
        m.rsvd  = 5'b0;
        m.gray  = gray;
        m.decim = decim;
        return m;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO with full/empty flags.
// Ports: clk_i, rst_i (async high), clr_i (sync flush), push_i/data_i,
// pop_i, data_o (0 while empty), full_o, empty_o.
module byte_fifo #(
    parameter int DEPTH = 64
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       pop_i,
    output logic [7:0] data_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_q;
    logic [AW:0] rd_q;
    logic        do_wr;
    logic        do_rd;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);

    // A push into a full FIFO is accepted when a pop frees a slot
    // on the same edge, so occupancy stays unchanged.
    assign do_rd = pop_i && !empty_o;
    assign do_wr = push_i && (!full_o || do_rd);

    assign data_o = empty_o ? 8'h00 : mem_q[rd_q[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else if (clr_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_wr) wr_q <= wr_q + 1'b1;
            if (do_rd) rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr && !clr_i) mem_q[wr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/pixel_stream_packer.sv
// Captures one windowed, optionally decimated frame and serialises it as
// a framed byte stream (A5 5A mode, then pixel bytes) through a byte FIFO.
// Ports: clk_clk/reset_reset, start + window/mode config, pix_* pixel input,
// out_data/out_valid/out_ready stream, busy, done pulse, sticky overflow.
module pixel_stream_packer
    import pix_stream_pkg::*;
#(
    parameter int COORD_W    = 11,
    parameter int FIFO_DEPTH = 64
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    input  logic               start,
    input  logic [COORD_W-1:0] win_x0,
    input  logic [COORD_W-1:0] win_y0,
    input  logic [COORD_W-1:0] win_w,
    input  logic [COORD_W-1:0] win_h,
    input  logic [1:0]         decim,
    input  logic               gray_mode,
    input  logic               pix_valid,
    input  logic [7:0]         pix_r,
    input  logic [7:0]         pix_g,
    input  logic [7:0]         pix_b,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               done,
    output logic               overflow
);

    localparam int CW = COORD_W + 1;

    state_e state_q, state_d;
    logic [COORD_W-1:0] x0_q, y0_q, w_q, h_q;
    logic [1:0]  decim_q;
    logic        gray_q;
    logic [1:0]  hdr_q, hdr_d;
    logic [23:0] ser_q, ser_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    logic        done_q, done_d;

    logic        cfg_load;
    logic        fifo_clr, fifo_push, fifo_pop;
    logic        fifo_full, fifo_empty;
    logic [7:0]  fifo_din;

    logic [CW-1:0] px, py, x0e, y0e, xend, yend, dx, dy, dmask;
    logic        x_in, y_in, dec_ok, is_last, sof, take, kept;
    logic        ser_push, ser_free, load, drop, start_ok;
    logic [9:0]  gsum;
    logic [7:0]  gbyte;

    // Window arithmetic is one bit wider than the coordinates so the
    // window end never wraps.
    assign px   = {1'b0, pix_x};
    assign py   = {1'b0, pix_y};
    assign x0e  = {1'b0, x0_q};
    assign y0e  = {1'b0, y0_q};
    assign xend = x0e + {1'b0, w_q};
    assign yend = y0e + {1'b0, h_q};
    assign dx   = px - x0e;
    assign dy   = py - y0e;
    assign dmask = CW'((4'd1 << decim_q) - 4'd1);

    assign x_in    = (px >= x0e) && (px < xend);
    assign y_in    = (py >= y0e) && (py < yend);
    assign dec_ok  = ((dx & dmask) == '0) && ((dy & dmask) == '0);
    assign is_last = pix_valid && (px == xend - CW'(1)) &&
                     (py == yend - CW'(1));
    assign sof     = pix_valid && (pix_x == '0) && (pix_y == '0);

    // The start-of-frame pixel is handled as a capture pixel on its edge.
    assign take = (state_q == ST_CAPTURE) ||
                  ((state_q == ST_WAIT_SOF) && sof);
    assign kept = take && pix_valid && x_in && y_in && dec_ok;

    assign gsum  = {2'b00, pix_r} + {1'b0, pix_g, 1'b0} + {2'b00, pix_b};
    assign gbyte = 8'(gsum >> 2);

    assign out_valid = !fifo_empty;
    assign fifo_pop  = out_valid && out_ready;

    // Serializer may push into a full FIFO only when a pop frees a slot.
    assign ser_push = (cnt_q != 2'd0) && (!fifo_full || fifo_pop);
    // Free on this edge if empty or its last byte leaves now.
    assign ser_free = (cnt_q == 2'd0) || ((cnt_q == 2'd1) && ser_push);
    assign load     = kept && ser_free;
    assign drop     = kept && !ser_free;

    assign start_ok = start && (state_q == ST_IDLE) &&
                      (win_w != '0) && (win_h != '0);

    always_comb begin
        state_d   = state_q;
        hdr_d     = hdr_q;
        ser_d     = ser_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        cfg_load  = 1'b0;
        fifo_clr  = 1'b0;
        fifo_push = 1'b0;
        fifo_din  = ser_q[23:16];

        if (ser_push) begin
            ser_d     = {ser_q[15:0], 8'h00};
            cnt_d     = cnt_q - 2'd1;
            fifo_push = 1'b1;
        end
        if (load) begin
            ser_d = gray_q ? {gbyte, 16'h0000} : {pix_r, pix_g, pix_b};
            cnt_d = gray_q ? 2'd1 : 2'd3;
        end
        if (drop) ovf_d = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d  = ST_HEADER;
                    hdr_d    = 2'd0;
                    ovf_d    = 1'b0;
                    fifo_clr = 1'b1;
                    cfg_load = 1'b1;
                end
            end
            ST_HEADER: begin
                fifo_push = 1'b1;
                unique case (hdr_q)
                    2'd0:    fifo_din = SYNC0;
                    2'd1:    fifo_din = SYNC1;
                    default: fifo_din = mode_byte(gray_q, decim_q);
                endcase
                hdr_d = hdr_q + 2'd1;
                if (hdr_q == 2'd2) state_d = ST_WAIT_SOF;
            end
            ST_WAIT_SOF: begin
                if (sof) state_d = is_last ? ST_DRAIN : ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (is_last) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if ((cnt_q == 2'd0) && fifo_empty) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q <= ST_IDLE;
            hdr_q   <= 2'd0;
            ser_q   <= 24'h0;
            cnt_q   <= 2'd0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            x0_q    <= '0;
            y0_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            decim_q <= 2'd0;
            gray_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            ser_q   <= ser_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            if (cfg_load) begin
                x0_q    <= win_x0;
                y0_q    <= win_y0;
                w_q     <= win_w;
                h_q     <= win_h;
                decim_q <= decim;
                gray_q  <= gray_mode;
            end
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_clk),
        .rst_i   (reset_reset),
        .clr_i   (fifo_clr),
        .push_i  (fifo_push),
        .data_i  (fifo_din),
        .pop_i   (fifo_pop),
        .data_o  (out_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_pixel_stream_packer.sv
// Self-checking bench for pixel_stream_packer.
// Table of capture configurations plus hand-written corner sequences.
module tb_pixel_stream_packer;

    localparam int COORD_W    = 11;
    localparam int FIFO_DEPTH = 64;
    localparam logic [7:0] FLAT_GRAY = 8'd20;

    logic               clk_clk = 1'b0;
    logic               reset_reset = 1'b1;
    logic               start = 1'b0;
    logic [COORD_W-1:0] win_x0 = '0, win_y0 = '0, win_w = '0, win_h = '0;
    logic [1:0]         decim = 2'd0;
    logic               gray_mode = 1'b0;
    logic               pix_valid = 1'b0;
    logic [7:0]         pix_r = '0, pix_g = '0, pix_b = '0;
    logic [COORD_W-1:0] pix_x = '0, pix_y = '0;
    logic [7:0]         out_data;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic               busy, done, overflow;

    pixel_stream_packer #(
        .COORD_W    (COORD_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .start       (start),
        .win_x0      (win_x0),
        .win_y0      (win_y0),
        .win_w       (win_w),
        .win_h       (win_h),
        .decim       (decim),
        .gray_mode   (gray_mode),
        .pix_valid   (pix_valid),
        .pix_r       (pix_r),
        .pix_g       (pix_g),
        .pix_b       (pix_b),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct {
        int x0; int y0; int w; int h;
        int decim; int gray; int flat;
        int fw; int fh;
        int exp_mode; int exp_bytes;
    } vec_t;

    vec_t vecs [6];
    logic [7:0] exp_q [$];
    int n_tests = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int rx_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    // Stream scoreboard: every accepted byte is compared with the queue.
    always @(negedge clk_clk) begin
        if (!reset_reset) begin
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                rx_cnt++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL stream_extra: got %02h expected none",
                             out_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        n_fail++;
                        $display("FAIL stream_byte: got %02h expected %02h",
                                 out_data, e);
                    end
                end
            end
        end
    end

    function automatic void pix_col(input int x, input int y, input int flat,
                                    output logic [7:0] r,
                                    output logic [7:0] g,
                                    output logic [7:0] b);
        if (flat != 0) begin
            r = 8'd10; g = 8'd20; b = 8'd30;
        end else begin
            r = 8'(x * 37 + y * 11 + 3);
            g = 8'(x * 7 + y * 53 + 90);
            b = 8'(255 - x * 13 - y * 5);
        end
    endfunction

    function automatic bit keep(input vec_t v, input int x, input int y);
        int s;
        s = 1 << v.decim;
        if (x < v.x0 || x >= v.x0 + v.w) return 1'b0;
        if (y < v.y0 || y >= v.y0 + v.h) return 1'b0;
        return ((x - v.x0) % s == 0) && ((y - v.y0) % s == 0);
    endfunction

    task automatic push_pix(input vec_t v, input int x, input int y);
        logic [7:0] r, g, b;
        pix_col(x, y, v.flat, r, g, b);
        if (v.gray != 0) begin
            if (v.flat != 0) exp_q.push_back(FLAT_GRAY);
            else exp_q.push_back(8'((int'(r) + 2 * int'(g) + int'(b)) / 4));
        end else begin
            exp_q.push_back(r);
            exp_q.push_back(g);
            exp_q.push_back(b);
        end
    endtask

    task automatic start_cfg(input vec_t v);
        win_x0 = COORD_W'(v.x0);
        win_y0 = COORD_W'(v.y0);
        win_w = COORD_W'(v.w);
        win_h = COORD_W'(v.h);
        decim = 2'(v.decim);
        gray_mode = (v.gray != 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        check("fifo_cleared", int'(out_valid), 0);
        check("overflow_cleared", int'(overflow), 0);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'(v.exp_mode));
        tick();
        check("sync0_visible", int'({out_valid, out_data}), 'h1A5);
        tick();
        tick();
    endtask

    task automatic send_frame(input vec_t v, input int gap, input bit model);
        logic [7:0] r, g, b;
        for (int y = 0; y < v.fh; y++) begin
            for (int x = 0; x < v.fw; x++) begin
                pix_col(x, y, v.flat, r, g, b);
                pix_valid = 1'b1;
                pix_x = COORD_W'(x);
                pix_y = COORD_W'(y);
                pix_r = r; pix_g = g; pix_b = b;
                if (model && keep(v, x, y)) push_pix(v, x, y);
                tick();
                pix_valid = 1'b0;
                repeat (gap) tick();
            end
        end
    endtask

    task automatic finish_vec(input vec_t v, input int bd, input int br,
                              input int exp_ovf);
        int k;
        k = 0;
        while (done_cnt == bd && k < 500) begin
            tick();
            k++;
        end
        repeat (3) tick();
        check("done_once", done_cnt - bd, 1);
        check("idle_after_done", int'(busy), 0);
        check("byte_count", rx_cnt - br, v.exp_bytes);
        check("queue_drained", exp_q.size(), 0);
        check("overflow_flag", int'(overflow), exp_ovf);
        exp_q.delete();
    endtask

    task automatic run_vec(input vec_t v);
        int bd, br;
        bd = done_cnt;
        br = rx_cnt;
        start_cfg(v);
        send_frame(v, 2, 1'b1);
        finish_vec(v, bd, br, 0);
    endtask

    initial begin
        vec_t vo, vb, vr;
        int bd, br;

        //          x0 y0 w h dec gray flat fw fh mode bytes
        vecs[0] = '{0, 0, 2, 2, 0, 0, 0, 4, 4, 'h00, 15};
        vecs[1] = '{0, 0, 2, 2, 0, 1, 1, 4, 4, 'h04, 7};
        vecs[2] = '{0, 0, 4, 4, 1, 0, 0, 4, 4, 'h01, 15};
        vecs[3] = '{1, 1, 3, 2, 0, 1, 0, 5, 4, 'h04, 9};
        vecs[4] = '{2, 1, 3, 3, 1, 0, 0, 6, 5, 'h01, 15};
        vecs[5] = '{0, 0, 8, 4, 3, 1, 0, 8, 4, 'h07, 4};
        vo = '{0, 0, 2, 2, 0, 0, 0, 4, 4, 'h00, 9};
        vb = '{0, 0, 7, 3, 0, 0, 0, 7, 3, 'h00, 66};
        vr = '{0, 0, 4, 4, 0, 0, 0, 4, 4, 'h00, 51};

        repeat (3) tick();
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_overflow", int'(overflow), 0);
        reset_reset = 1'b0;
        tick();

        win_w = '0;
        win_h = COORD_W'(2);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("zero_size_ignored", int'(busy), 0);
        tick();
        check("zero_size_no_data", int'(out_valid), 0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Back-to-back RGB pixels: second of each pair is dropped.
        bd = done_cnt;
        br = rx_cnt;
        start_cfg(vo);
        push_pix(vo, 0, 0);
        push_pix(vo, 0, 1);
        send_frame(vo, 0, 1'b0);
        finish_vec(vo, bd, br, 1);
        run_vec(vecs[0]);

        // Consumer stalled for >200 cycles; FIFO fills and serializer waits.
        bd = done_cnt;
        br = rx_cnt;
        out_ready = 1'b0;
        start_cfg(vb);
        send_frame(vb, 2, 1'b1);
        repeat (140) tick();
        check("held_valid", int'(out_valid), 1);
        check("held_no_done", done_cnt - bd, 0);
        check("held_busy", int'(busy), 1);
        check("held_no_rx", rx_cnt - br, 0);
        out_ready = 1'b1;
        finish_vec(vb, bd, br, 0);

        // Reset in the middle of a capture.
        start_cfg(vr);
        out_ready = 1'b0;
        for (int x = 0; x < 3; x++) begin
            pix_valid = 1'b1;
            pix_x = COORD_W'(x);
            pix_y = '0;
            pix_r = 8'(x + 1); pix_g = 8'h11; pix_b = 8'h22;
            tick();
        end
        pix_valid = 1'b0;
        tick();
        check("midcap_busy", int'(busy), 1);
        check("midcap_valid", int'(out_valid), 1);
        reset_reset = 1'b1;
        #1;
        check("midrst_out_data", int'(out_data), 0);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_overflow", int'(overflow), 0);
        exp_q.delete();
        tick();
        reset_reset = 1'b0;
        out_ready = 1'b1;
        tick();
        run_vec(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
